// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions and
// the hex-to-segment table (active-high, a in bit 0).
package seg_scan_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
      case (val)
         4'h0:    hex_to_seg = 7'h3F;
         4'h1:    hex_to_seg = 7'h06;
         4'h2:    hex_to_seg = 7'h5B;
         4'h3:    hex_to_seg = 7'h4F;
         4'h4:    hex_to_seg = 7'h66;
         4'h5:    hex_to_seg = 7'h6D;
         4'h6:    hex_to_seg = 7'h7D;
         4'h7:    hex_to_seg = 7'h07;
         4'h8:    hex_to_seg = 7'h7F;
         4'h9:    hex_to_seg = 7'h6F;
         4'hA:    hex_to_seg = 7'h77;
         4'hB:    hex_to_seg = 7'h7C;
         4'hC:    hex_to_seg = 7'h39;
         4'hD:    hex_to_seg = 7'h5E;
         4'hE:    hex_to_seg = 7'h79;
         default: hex_to_seg = 7'h71;
      endcase
   endfunction

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Combinational hex digit to active-high segment pattern; polarity is the
// caller's concern.
module hex7seg_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0]         i_val,
   output logic [SEG_G:SEG_A] o_seg
);

   assign o_seg = hex_to_seg(i_val);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with PWM brightness, a dark guard
// tick at the start of every digit slot and a frame-synchronous shadow buffer.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int DIV         = 98,
   parameter int BRIGHT_W    = 4,
   parameter int SEG_ACT_LOW = 1,
   parameter int SEL_ACT_LOW = 1
)
(
   input  logic                    clk,
   input  logic                    nRst,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   digits,
   input  logic [N_DIGITS-1:0]     dp,
   input  logic [N_DIGITS-1:0]     blank,
   input  logic [BRIGHT_W-1:0]     bright,
   output logic                    load_ack,
   output logic                    frame_start,
   output logic [7:0]              seg_dat,
   output logic [N_DIGITS-1:0]     seg_sel
);

   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int D_W   = $clog2(N_DIGITS);
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [D_W-1:0]      D_LAST   = D_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] SEL_OFF  = (SEL_ACT_LOW != 0) ? '1 : '0;
   localparam logic [7:0]          DAT_OFF  = (SEG_ACT_LOW != 0) ? '1 : '0;

   logic [PRE_W-1:0]      r_pre;
   logic [BRIGHT_W-1:0]   r_t;
   logic [D_W-1:0]        r_d;

   logic [4*N_DIGITS-1:0] r_sh_digits;
   logic [N_DIGITS-1:0]   r_sh_dp;
   logic [N_DIGITS-1:0]   r_sh_blank;
   logic [BRIGHT_W-1:0]   r_sh_bright;

   logic [N_DIGITS-1:0]   r_sel;
   logic [7:0]            r_dat;
   logic                  r_ack;
   logic                  r_frame;

   logic                  w_tick;
   logic                  w_t_wrap;
   logic                  w_boundary;
   logic                  w_capture;
   logic                  w_active;
   logic [3:0]            w_nibble;
   logic [SEG_G:SEG_A]    w_seg7;
   logic [7:0]            w_pat;
   logic [N_DIGITS-1:0]   w_onehot;
   logic [N_DIGITS-1:0]   w_sel_nxt;
   logic [7:0]            w_dat_nxt;

   assign w_tick     = (r_pre == PRE_LAST);
   assign w_t_wrap   = w_tick && (r_t == '1);
   assign w_boundary = (r_pre == '0) && (r_t == '0) && (r_d == D_LAST);
   assign w_capture  = w_boundary && load;
   assign w_nibble   = r_sh_digits[{r_d, 2'b00} +: 4];

   hex7seg_decode u_dec (
      .i_val (w_nibble),
      .o_seg (w_seg7)
   );

   // Digits scan from the highest index down, one slot each.
   always_ff @(posedge clk) begin
      if (nRst) begin
         r_pre <= '0;
         r_t   <= '0;
         r_d   <= D_LAST;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + 1'b1;
         if (w_tick)
            r_t <= r_t + 1'b1;
         if (w_t_wrap)
            r_d <= (r_d == '0) ? D_LAST : r_d - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (nRst) begin
         r_sh_digits <= '0;
         r_sh_dp     <= '0;
         r_sh_blank  <= '1;
         r_sh_bright <= '0;
      end else if (w_capture) begin
         r_sh_digits <= digits;
         r_sh_dp     <= dp;
         r_sh_blank  <= blank;
         r_sh_bright <= bright;
      end
   end

   // t==0 is the guard tick, so the shadow swap at the boundary is never seen mid-digit.
   always_comb begin
      w_onehot              = '0;
      w_onehot[r_d]         = 1'b1;
      w_pat                 = '0;
      w_pat[SEG_G:SEG_A]    = w_seg7;
      w_pat[SEG_DP]         = r_sh_dp[r_d];
      w_active              = (r_t != '0) && (r_t <= r_sh_bright) && !r_sh_blank[r_d];
      w_sel_nxt             = w_active ? (w_onehot ^ SEL_OFF) : SEL_OFF;
      w_dat_nxt             = w_active ? (w_pat ^ DAT_OFF) : DAT_OFF;
   end

   always_ff @(posedge clk) begin
      if (nRst) begin
         r_sel   <= SEL_OFF;
         r_dat   <= DAT_OFF;
         r_ack   <= 1'b0;
         r_frame <= 1'b0;
      end else begin
         r_sel   <= w_sel_nxt;
         r_dat   <= w_dat_nxt;
         r_ack   <= w_capture;
         r_frame <= w_boundary;
      end
   end

   assign seg_sel     = r_sel;
   assign seg_dat     = r_dat;
   assign load_ack    = r_ack;
   assign frame_start = r_frame;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver at N_DIGITS=4, DIV=2, BRIGHT_W=2 (slot 8, frame 32).
// Outputs are compared every cycle with a frame-position model and per vector.
module tb_seg_scan_driver;

   localparam int N     = 4;
   localparam int DIV   = 2;
   localparam int BW    = 2;
   localparam int TICKS = 4;
   localparam int SLOT  = DIV * TICKS;
   localparam int FRAME = N * SLOT;

   logic        clk = 1'b0;
   logic        nRst;
   logic        load;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic [1:0]  bright;
   logic        load_ack;
   logic        frame_start;
   logic [7:0]  seg_dat;
   logic [3:0]  seg_sel;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .N_DIGITS    (N),
      .DIV         (DIV),
      .BRIGHT_W    (BW),
      .SEG_ACT_LOW (1),
      .SEL_ACT_LOW (1)
   ) dut (
      .clk         (clk),
      .nRst        (nRst),
      .load        (load),
      .digits      (digits),
      .dp          (dp),
      .blank       (blank),
      .bright      (bright),
      .load_ack    (load_ack),
      .frame_start (frame_start),
      .seg_dat     (seg_dat),
      .seg_sel     (seg_sel)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: frame position -> outputs ----------------
   logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [13:0] exp_q [$];
   int          m_phase;
   logic [15:0] m_digits;
   logic [3:0]  m_dp, m_blank;
   logic [1:0]  m_bright;

   always @(posedge clk) begin
      int         t, d;
      logic       act, e_ack, e_fs;
      logic [3:0] e_sel, nib;
      logic [7:0] e_dat;
      if (nRst) begin
         e_sel = 4'hF; e_dat = 8'hFF; e_ack = 1'b0; e_fs = 1'b0;
         m_phase = 0; m_digits = '0; m_dp = '0; m_blank = 4'hF; m_bright = '0;
      end else begin
         t     = (m_phase / DIV) % TICKS;
         d     = N - 1 - m_phase / SLOT;
         nib   = 4'(m_digits >> (4 * d));
         act   = (t >= 1) && (t <= int'(m_bright)) && !m_blank[d];
         e_sel = act ? ~(4'b0001 << d) : 4'hF;
         e_dat = act ? ~{m_dp[d], hex_tab[nib]} : 8'hFF;
         e_fs  = (m_phase == 0);
         e_ack = (m_phase == 0) && (load === 1'b1);
         if (e_ack) begin
            m_digits = digits; m_dp = dp; m_blank = blank; m_bright = bright;
         end
         m_phase = (m_phase + 1) % FRAME;
      end
      exp_q.push_back({e_sel, e_dat, e_ack, e_fs});
   end

   always @(negedge clk) begin
      logic [13:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("model_sel", 32'(seg_sel), 32'(e[13:10]));
         check("model_dat", 32'(seg_dat), 32'(e[9:2]));
         check("model_ack", 32'(load_ack), 32'(e[1]));
         check("model_fs",  32'(frame_start), 32'(e[0]));
      end
   end

   // ---------------- vector table ----------------
   typedef struct packed {
      logic [15:0]     digits;
      logic [3:0]      dp;
      logic [3:0]      blank;
      logic [1:0]      bright;
      logic [3:0][3:0] on_cnt;
      logic [3:0][7:0] dat;
   } vec_t;

   vec_t vecs [6];

   function automatic vec_t mk(input logic [15:0] dg, input logic [3:0] p, input logic [3:0] b,
                               input logic [1:0] br, input logic [3:0][3:0] on,
                               input logic [3:0][7:0] dt);
      vec_t v;
      v.digits = dg; v.dp = p; v.blank = b; v.bright = br; v.on_cnt = on; v.dat = dt;
      return v;
   endfunction

   task automatic old_chk(input vec_t p, input bit en, inout int bad);
      for (int d = 0; d < N; d++) begin
         logic [3:0] m;
         m = 4'b0001 << d;
         if (en && seg_sel == ~m && seg_dat !== p.dat[d]) bad++;
      end
   endtask

   task automatic apply_vec(input int idx);
      vec_t v, p;
      int   on [4];
      int   bad_val, bad_dark, bad_old, acks;
      bit   got, found;
      v = vecs[idx];
      p = vecs[(idx > 0) ? idx - 1 : 0];
      bad_old = 0;
      repeat ($urandom_range(3, 40)) begin
         @(negedge clk);
         old_chk(p, idx > 0, bad_old);
      end
      digits = v.digits; dp = v.dp; blank = v.blank; bright = v.bright; load = 1'b1;
      got = 1'b0;
      for (int i = 0; i < FRAME + 2 && !got; i++) begin
         @(negedge clk);
         old_chk(p, idx > 0, bad_old);
         if (load_ack === 1'b1) got = 1'b1;
      end
      check($sformatf("vec%0d_old_display", idx), bad_old, 0);
      check($sformatf("vec%0d_ack_seen", idx), 32'(got), 1);
      load = 1'b0;
      if (!got) return;
      on = '{default: 0};
      bad_val = 0; bad_dark = 0; acks = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge clk);
         if (load_ack === 1'b1) acks++;
         if (seg_sel === 4'hF) begin
            if (seg_dat !== 8'hFF) bad_dark++;
         end else begin
            found = 1'b0;
            for (int d = 0; d < N; d++) begin
               logic [3:0] m;
               m = 4'b0001 << d;
               if (seg_sel === ~m) begin
                  found = 1'b1;
                  on[d]++;
                  if (seg_dat !== v.dat[d]) bad_val++;
               end
            end
            if (!found) bad_dark++;
         end
      end
      for (int d = 0; d < N; d++)
         check($sformatf("vec%0d_on_cycles_d%0d", idx, d), on[d], 32'(v.on_cnt[d]));
      check($sformatf("vec%0d_bad_pattern", idx), bad_val, 0);
      check($sformatf("vec%0d_bad_dark", idx), bad_dark, 0);
      check($sformatf("vec%0d_ack_count", idx), acks, 1);
   endtask

   // Called on the negedge right after the last reset edge; releases reset.
   task automatic release_and_watch(input string tag, input int n);
      int bad_dark, acks;
      check({tag, "_sel"}, 32'(seg_sel), 32'h0F);
      check({tag, "_dat"}, 32'(seg_dat), 32'hFF);
      check({tag, "_ack"}, 32'(load_ack), 0);
      check({tag, "_fs"},  32'(frame_start), 0);
      nRst = 1'b0; load = 1'b0;
      bad_dark = 0; acks = 0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         check($sformatf("%s_fs_k%0d", tag, k), 32'(frame_start), 32'((k % FRAME) == 1));
         if (seg_sel !== 4'hF || seg_dat !== 8'hFF) bad_dark++;
         if (load_ack !== 1'b0) acks++;
      end
      check({tag, "_dark_cycles"}, bad_dark, 0);
      check({tag, "_spurious_ack"}, acks, 0);
   endtask

   task automatic load_wait(input string tag);
      bit got;
      load = 1'b1;
      got  = 1'b0;
      for (int i = 0; i < FRAME + 2 && !got; i++) begin
         @(negedge clk);
         if (load_ack === 1'b1) got = 1'b1;
      end
      check({tag, "_ack_seen"}, 32'(got), 1);
      load = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = mk(16'h1234, 4'h0, 4'h0, 2'd3, {4'd6, 4'd6, 4'd6, 4'd6}, {8'hF9, 8'hA4, 8'hB0, 8'h99});
      vecs[1] = mk(16'h1234, 4'h0, 4'h0, 2'd1, {4'd2, 4'd2, 4'd2, 4'd2}, {8'hF9, 8'hA4, 8'hB0, 8'h99});
      vecs[2] = mk(16'h1234, 4'h0, 4'h0, 2'd0, {4'd0, 4'd0, 4'd0, 4'd0}, {8'hF9, 8'hA4, 8'hB0, 8'h99});
      vecs[3] = mk(16'h1234, 4'h1, 4'h2, 2'd3, {4'd6, 4'd6, 4'd0, 4'd6}, {8'hF9, 8'hA4, 8'hFF, 8'h19});
      vecs[4] = mk(16'hABCD, 4'h0, 4'h0, 2'd3, {4'd6, 4'd6, 4'd6, 4'd6}, {8'h88, 8'h83, 8'hC6, 8'hA1});
      vecs[5] = mk(16'h80EF, 4'hF, 4'h0, 2'd2, {4'd4, 4'd4, 4'd4, 4'd4}, {8'h00, 8'h40, 8'h06, 8'h0E});

      // clock/reset: hold reset 5 cycles
      nRst = 1'b1; load = 1'b0; digits = '0; dp = '0; blank = '0; bright = '0;
      repeat (5) @(negedge clk);
      release_and_watch("reset", 70);

      for (int i = 0; i < 6; i++) apply_vec(i);

      // randomized loads, checked cycle by cycle against the model
      for (int i = 0; i < 25; i++) begin
         digits = 16'($urandom);
         dp     = 4'($urandom_range(0, 15));
         blank  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         bright = 2'($urandom_range(0, 3));
         load_wait($sformatf("rand%0d", i));
         repeat ($urandom_range(0, 45)) @(negedge clk);
      end

      // reset pulse mid-slot with a pending load
      digits = 16'h5678; dp = 4'h0; blank = 4'h0; bright = 2'd3;
      load_wait("pre_pulse");
      repeat (13) @(negedge clk);
      digits = 16'h9999; load = 1'b1;
      @(negedge clk);
      nRst = 1'b1;
      @(negedge clk);
      release_and_watch("pulse", 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment driver and successor to the fixed 4-digit scanner. It scans N digits and decodes 4-bit hex values to segment patterns. It adds per-digit decimal point and blanking, PWM brightness with an inter-digit guard slot against ghosting, and a shadow display buffer loaded by a frame-synchronous request/ack handshake. It sits between status/counter logic and the board's common-cathode/anode display pins.

## Interface
- N_DIGITS, 4: number of digits scanned (2..8).
- DIV, 98: clk cycles per brightness tick (≥1); 25 MHz → ~4 kHz frame at defaults.
- BRIGHT_W, 4: brightness width; slot = 2^BRIGHT_W ticks.
- SEG_ACT_LOW, 1: seg_dat active level is 0 when 1.
- SEL_ACT_LOW, 1: seg_sel active level is 0 when 1.
- clk  in  1  system clock.
- nRst  in  1  reset, synchronous, active-high (name kept for codebase consistency).
- load  in  1  request to capture digits/dp/blank/bright into shadow buffer; level, held until load_ack.
- digits  in  4*N_DIGITS  hex value per digit, digit i at [4i+3:4i].
- dp  in  N_DIGITS  decimal point on, per digit.
- blank  in  N_DIGITS  digit forced dark, per digit.
- bright  in  BRIGHT_W  on-ticks per slot; 0 = dark.
- load_ack  out  1  one-cycle pulse: shadow captured.
- frame_start  out  1  one-cycle pulse per frame.
- seg_dat  out  8  bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
- seg_sel  out  N_DIGITS  digit i enable at seg_sel[i].

## Operation
- Counters: pre in 0..DIV-1; tick when pre==DIV-1. t in 0..2^BRIGHT_W-1, advances on tick. d scans N_DIGITS-1 down to 0 and decrements when t wraps; it wraps 0→N_DIGITS-1.
- Boundary state: (pre,t,d) = (0,0,N_DIGITS-1).
- Digit d is active when 1 ≤ t ≤ shadow bright and !shadow blank[d]. t=0 is always a guard slot with everything dark.
- Active digit: seg_sel has only bit d at active level. seg_dat = decode(shadow digit d), with bit7 = shadow dp[d], applied at SEG_ACT_LOW polarity.
- Inactive: all seg_sel bits inactive; all seg_dat bits off.
- Shadow capture: at the edge ending a boundary-state cycle, if load=1, the shadow takes digits/dp/blank/bright. load outside the boundary is ignored until the next boundary. Inputs must be stable while load is high.
- load_ack and frame_start: high for exactly the cycle after each boundary-state cycle. load_ack additionally requires that a capture occurred.
- bright = 2^BRIGHT_W-1 gives maximum duty: (2^BRIGHT_W-1)/2^BRIGHT_W.
- Reset: counters go to the boundary state. Shadow: digits=0, dp=0, blank=all ones, bright=0. Output reset values:
  - seg_sel all inactive (4'hF at defaults).
  - seg_dat all off (8'hFF at defaults).
  - load_ack=0, frame_start=0.
- Reset mid-frame aborts the scan and discards any pending load. Reset has priority over load in the same cycle.

## Timing
- All outputs are registered. Output values in cycle k+1 derive from the counter state and shadow in cycle k.
- First boundary is the first cycle after nRst deasserts. frame_start is high in the cycle after that.
- Slot = DIV·2^BRIGHT_W cycles. Frame = N_DIGITS·slot cycles.
- A new shadow value is first visible in the first t=1 cycle of digit N_DIGITS-1, i.e. DIV+1 cycles after capture. Because it lands in the guard slot, no torn frame is possible.
- Maximum load-to-ack latency is one frame + 1 cycle.

## Structure
- Package seg_scan_pkg:
  - 16-entry hex→7-seg active-high table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - Segment bit-index constants.
- Sub-module hex7seg_decode: combinational; 4-bit value in, 7-bit active-high pattern out. Polarity is applied in the top level.
- Top level contains the counters, shadow registers and output registers.

## Test plan
Bench parameters: N_DIGITS=4, DIV=2, BRIGHT_W=2 (slot 8 cycles, frame 32 cycles).
- Reset held 5 cycles, then released with load=0 → seg_sel=4'hF, seg_dat=8'hFF indefinitely; frame_start pulses every 32 cycles, first in the cycle after release.
- load=1, digits=16'h1234, dp=0, blank=0, bright=3 → load_ack one cycle at the next boundary. Then per slot:
  - seg_sel=4'b0111, seg_dat=8'hF9 for 6 of 8 cycles.
  - Then 4'b1011 with 8'hA4, 4'b1101 with 8'hB0, 4'b1110 with 8'h99.
  - Dark during each t=0 guard.
- bright=1 → each digit on 2 cycles per slot. bright=0 → fully dark; frame_start continues.
- load raised mid-frame with digits=16'hABCD → display keeps 1234 until the boundary. load_ack is exactly one cycle, and digit 3 then shows 8'h88.
- blank=4'b0010, dp=4'b0001 → seg_sel[1] never active. Digit 0 shows bit7=0 (e.g. '4' → 8'h19). All other digits have bit7=1.
- nRst pulsed for 1 cycle mid-slot while load=1 → next cycle outputs are all-off. No load_ack is issued for the aborted request. The scan restarts at the boundary with blank=all ones.
